multicycle_controller: RTL
==========================

# multicycle_controller

Multicycle control unit for the RISC-V core: a Moore/Mealy FSM that sequences each instruction over 3–5 cycles through a shared ALU and single memory port, replacing the single-cycle decoder path. It sits beside the multicycle datapath, consuming the latched instruction fields and live ALU flags, and driving all datapath enables and muxes. It adds an illegal-opcode trap and an optional memory wait handshake.

## Interface

- Parameters
  - `ALUCTRL_W`, default 4: width of `ALUControl`.
  - `IMMSRC_W`, default 3: width of `ImmSrc`.
- Ports
  - Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk`, input, 1: rising-edge clock.
  - `reset`, input, 1: asynchronous, active-high reset.
  - `op`, input, 7: opcode from the instruction register.
  - `funct3`, input, 3: from the instruction register.
  - `funct7b5`, input, 1: instruction bit 30.
  - `flags`, input, 4: {N, Z, C, V} from the live ALU result. C=1 means no borrow on subtract.
  - `mem_ready`, input, 1: memory done. Present only with `MC_MEM_WAIT_EN`.
  - `PCWrite`, output, 1: PC register enable.
  - `AdrSrc`, output, 1: memory address select. 0 = PC, 1 = Result.
  - `MemWrite`, output, 1: data memory write.
  - `IRWrite`, output, 1: latch instruction and OldPC.
  - `ResultSrc`, output, 2: result mux. 00 = ALUOut, 01 = Data, 10 = ALUResult.
  - `ALUSrcA`, output, 2: ALU A mux. 00 = PC, 01 = OldPC, 10 = rs1 (A), 11 = zero.
  - `ALUSrcB`, output, 2: ALU B mux. 00 = rs2, 01 = imm, 10 = 4.
  - `ImmSrc`, output, `IMMSRC_W`: immediate type. I = 0, S = 1, B = 2, J = 3, U = 4.
  - `ALUControl`, output, `ALUCTRL_W`: ALU operation code.
  - `RegWrite`, output, 1: register file write.
  - `illegal`, output, 1: sticky illegal-instruction flag.
  - `state`, output, 4: current state encoding, for debug.

## Operation

- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, JALWB, UPPER, TRAP.
- Any output not listed for a state is 0. `ALUControl` is ADD unless listed.
- FETCH
  - AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, PCWrite=1.
  - Next state: DECODE.
- DECODE
  - ALUSrcA=01, ALUSrcB=01, ADD. This computes the branch/JAL target into ALUOut.
  - Next state by `op`:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 or 0010111 → UPPER
    - any other `op` → TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01. Next state is MEMREAD if `op[5]`=0, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Next state: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next state: FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. Next state: FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, `ALUControl` from the R-type decode. Next state: ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, `ALUControl` from the I-type decode. `funct7b5` is honoured only for SRAI. Next state: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next state: FETCH.
- BRANCH
  - ALUSrcA=10, ALUSrcB=00, SUB, ResultSrc=00.
  - PCWrite = taken, evaluated combinationally from `flags` in this cycle:
    - beq: Z
    - bne: !Z
    - blt: N^V
    - bge: !(N^V)
    - bltu: !C
    - bgeu: C
  - `funct3` 010 or 011 → TRAP.
  - Next state: FETCH.
- JAL: ResultSrc=00, PCWrite=1, ALUSrcA=01, ALUSrcB=10. ALUOut ← OldPC+4. Next state: ALUWB.
- JALR: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, PCWrite=1. Next state: JALWB.
- JALWB: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, RegWrite=1. Next state: FETCH.
- UPPER: ALUSrcA = 11 if `op[5]`=1 (LUI), else 01 (AUIPC). ALUSrcB=01. Next state: ALUWB.
- TRAP: all enables 0, `illegal`=1. Stays in TRAP until reset.
- `ImmSrc` is decoded combinationally from `op` in every state. It defaults to 0 for unknown opcodes.
- ALUControl encodings:
  - ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100
  - SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001
  - Upper bits are zero-extended when `ALUCTRL_W` > 4.

## Timing

- Reset
  - State goes to FETCH immediately on assertion.
  - `illegal` clears to 0. `state`=0 (FETCH). All other outputs take their FETCH values, so the first fetch occurs in the first clock after deassertion.
  - Reset mid-instruction abandons the instruction. No partial writes occur after the reset edge.
- One state transition per rising edge. Enables are valid in the cycle of their state.
- Latency in cycles, FETCH inclusive:
  - lw: 5
  - sw, R, I, jal, jalr, lui, auipc: 4
  - branch: 3, taken or not.
- Flag dependence: only PCWrite in BRANCH depends combinationally on `flags`. All other outputs depend on state, `op`, `funct3` and `funct7b5`.

## Configuration

- `MC_MEM_WAIT_EN` defined:
  - The `mem_ready` port exists.
  - FETCH, MEMREAD and MEMWRITE hold their state while `mem_ready`=0.
  - MemWrite and AdrSrc stay asserted while holding.
  - In FETCH, IRWrite and PCWrite are asserted only in the cycle `mem_ready`=1.
  - In MEMREAD the state advances when `mem_ready`=1.
- `MC_MEM_WAIT_EN` undefined:
  - No `mem_ready` port. Behaviour is identical to `mem_ready` tied to 1.

## Structure

- Shared package `mc_ctrl_pkg` holds:
  - the state enum;
  - the ALUControl codes;
  - the ResultSrc, ALUSrcA, ALUSrcB and ImmSrc encodings;
  - the opcode constants.
- One sub-module, `ctrl_alu_dec`: a combinational map from (`op[5]`, `funct3`, `funct7b5`, alu-mode) to `ALUControl`. Alu-mode is ADD, SUB, or FUNCT.
- The FSM and output decode live in `multicycle_controller`.

## Test plan

- addi x1,x0,5 (`op`=0010011, `funct3`=000) → states FETCH, DECODE, EXECI, ALUWB. RegWrite=1 only in cycle 4. ALUControl=0000 in EXECI.
- lw (0000011) → 5 states. AdrSrc=1 in MEMREAD. ResultSrc=01 with RegWrite=1 in MEMWB.
- beq with flags Z=1 → PCWrite=1 in BRANCH. With Z=0 → PCWrite=0. Both return to FETCH after 3 cycles. bltu with flags C=0 → taken.
- jalr (1100111) → PCWrite=1 with ResultSrc=10 in JALR. RegWrite=1 with ALUSrcA=01, ALUSrcB=10 in JALWB.
- Opcode 1111111 → TRAP after DECODE. `illegal`=1 and remains 1 for 10 cycles. Reset then returns to FETCH with `illegal`=0.
- Reset asserted in MEMWRITE → MemWrite=0 immediately. With `MC_MEM_WAIT_EN` and `mem_ready`=0 for 3 cycles in FETCH → IRWrite=0 for those cycles, then 1 in the ready cycle.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared states, ALU codes, mux encodings and opcodes for the multicycle controller
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, BRANCH, JAL, JALR, JALWB, UPPER, TRAP
    } state_t;

    typedef enum logic [1:0] {MODE_ADD, MODE_SUB, MODE_FUNCT} alu_mode_t;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    function automatic logic [2:0] imm_src(input logic [6:0] op);
        case (op)
            OP_STORE:        return IMM_S;
            OP_BRANCH:       return IMM_B;
            OP_JAL:          return IMM_J;
            OP_LUI, OP_AUIPC: return IMM_U;
            default:         return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_alu_dec.sv
// ctrl_alu_dec: maps opcode bit 5, funct3, funct7b5 and alu mode onto the ALU operation code
module ctrl_alu_dec
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 4
) (
    input  logic                 op5,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  alu_mode_t            alu_mode,
    output logic [ALUCTRL_W-1:0] alu_control
);

    logic [3:0] code;

    // funct7b5 selects SUB only for R-type adds; it selects SRA for both shift-right forms
    always_comb begin
        code = ALU_ADD;
        if (alu_mode == MODE_SUB)
            code = ALU_SUB;
        else if (alu_mode == MODE_FUNCT)
            case (funct3)
                3'b000:  code = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                3'b001:  code = ALU_SLL;
                3'b010:  code = ALU_SLT;
                3'b011:  code = ALU_SLTU;
                3'b100:  code = ALU_XOR;
                3'b101:  code = funct7b5 ? ALU_SRA : ALU_SRL;
                3'b110:  code = ALU_OR;
                default: code = ALU_AND;
            endcase
    end

    assign alu_control = ALUCTRL_W'(code);

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: RISC-V multicycle FSM; define MC_MEM_WAIT_EN to add the mem_ready wait handshake
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 4,
    parameter int IMMSRC_W  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic [3:0]           flags,
`ifdef MC_MEM_WAIT_EN
    input  logic                 mem_ready,
`endif
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [IMMSRC_W-1:0]  ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 RegWrite,
    output logic                 illegal,
    output logic [3:0]           state
);

    state_t    state_q, state_d;
    logic      illegal_q, illegal_d;
    logic      rdy, taken;
    alu_mode_t alu_mode;

`ifdef MC_MEM_WAIT_EN
    assign rdy = mem_ready;
`else
    assign rdy = 1'b1;
`endif

    // Branch decision from live flags {N,Z,C,V}; reserved funct3 values never take
    always_comb begin
        case (funct3)
            3'b000:  taken = flags[2];
            3'b001:  taken = !flags[2];
            3'b100:  taken = flags[3] ^ flags[0];
            3'b101:  taken = !(flags[3] ^ flags[0]);
            3'b110:  taken = !flags[1];
            3'b111:  taken = flags[1];
            default: taken = 1'b0;
        endcase
    end

    // Next-state sequencing; memory states hold until the port reports ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    if (rdy) state_d = DECODE;
            DECODE:
                case (op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_R:              state_d = EXECR;
                    OP_I:              state_d = EXECI;
                    OP_BRANCH:         state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    OP_JALR:           state_d = JALR;
                    OP_LUI, OP_AUIPC:  state_d = UPPER;
                    default:           state_d = TRAP;
                endcase
            MEMADR:   state_d = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  if (rdy) state_d = MEMWB;
            MEMWRITE: if (rdy) state_d = FETCH;
            EXECR, EXECI, JAL, UPPER: state_d = ALUWB;
            BRANCH:   state_d = (funct3[2:1] == 2'b01) ? TRAP : FETCH;
            JALR:     state_d = JALWB;
            TRAP:     state_d = TRAP;
            default:  state_d = FETCH;
        endcase
        illegal_d = illegal_q | (state_d == TRAP);
    end

    // Moore datapath controls per state; only the BRANCH PC enable looks at flags
    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        alu_mode  = MODE_ADD;
        case (state_q)
            FETCH: begin
                IRWrite   = rdy;
                PCWrite   = rdy;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            EXECR: begin
                ALUSrcA  = SRCA_RS1;
                alu_mode = MODE_FUNCT;
            end
            EXECI: begin
                ALUSrcA  = SRCA_RS1;
                ALUSrcB  = SRCB_IMM;
                alu_mode = MODE_FUNCT;
            end
            ALUWB:    RegWrite = 1'b1;
            BRANCH: begin
                ALUSrcA  = SRCA_RS1;
                alu_mode = MODE_SUB;
                PCWrite  = taken;
            end
            JAL: begin
                PCWrite = 1'b1;
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
            end
            JALR: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                PCWrite   = 1'b1;
            end
            JALWB: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                RegWrite  = 1'b1;
            end
            UPPER: begin
                ALUSrcA = op[5] ? SRCA_ZERO : SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            default: ;
        endcase
    end

    // State and sticky trap flag; reset abandons any instruction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    ctrl_alu_dec #(.ALUCTRL_W(ALUCTRL_W)) u_alu_dec (
        .op5         (op[5]),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .alu_mode    (alu_mode),
        .alu_control (ALUControl)
    );

    assign ImmSrc  = IMMSRC_W'(imm_src(op));
    assign illegal = illegal_q;
    assign state   = state_q;

endmodule
